// File: rtl/sparse_tree_adder_pkg.sv
// Shared types and helpers for the sparse Sklansky adder: the (g,p) pair,
// the valence-2 prefix operator and the tree depth calculation.
package sparse_tree_adder_pkg;

  localparam int SPARSITY = 4;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  // Valence-2 prefix operator: hi covers the more significant span.
  function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
    pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  // Block-level Sklansky levels needed for an n-bit operand.
  function automatic int prefix_levels(input int n);
    return $clog2(n / SPARSITY);
  endfunction

endpackage

// File: rtl/sparse_tree_adder_carry_select.sv
// 4-bit carry-select slice: two ripple sums (carry 0 / carry 1) and a mux
// driven by the group carry from the prefix tree.
module carry_select_block
  import sparse_tree_adder_pkg::*;
(
  input  logic [SPARSITY-1:0] a,
  input  logic [SPARSITY-1:0] b,
  input  logic                cin,
  output logic [SPARSITY-1:0] sum
);

  logic [SPARSITY-1:0] sum_c0;
  logic [SPARSITY-1:0] sum_c1;

  assign sum_c0 = a + b;
  assign sum_c1 = a + b + 4'd1;
  assign sum    = cin ? sum_c1 : sum_c0;

endmodule

// File: rtl/sparse_tree_adder.sv
// Sklansky valence-2 prefix adder with sparsity 4: the tree yields only every
// fourth carry, and 4-bit carry-select slices form the sum. Purely combinational.
module sparse_tree_adder
  import sparse_tree_adder_pkg::*;
#(
  parameter int N_BIT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BIT-1:0] operand_1,
  input  logic [N_BIT-1:0] operand_2,
  input  logic             carry_in,
  output logic [N_BIT-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int M = N_BIT / SPARSITY;
  localparam int L = prefix_levels(N_BIT);

  pg_t        bit_pg [N_BIT];
  pg_t        blk_pg [M];
  logic [M:0] grp_c;
  logic [M-1:0] unused_p;
  logic       unused_ports;

  // Clock and reset exist only for port uniformity.
  assign unused_ports = clk ^ rst;

  // Bitwise generate/propagate; carry_in is folded into bit 0's generate.
  for (genvar i = 0; i < N_BIT; i++) begin : g_bit
    if (i == 0) begin : g_fold
      assign bit_pg[i].g = (operand_1[i] & operand_2[i])
                         | ((operand_1[i] ^ operand_2[i]) & carry_in);
    end else begin : g_plain
      assign bit_pg[i].g = operand_1[i] & operand_2[i];
    end
    assign bit_pg[i].p = operand_1[i] ^ operand_2[i];
  end

  // First two prefix levels collapse each 4-bit slice into one (G,P).
  for (genvar k = 0; k < M; k++) begin : g_blk
    pg_t pair_lo;
    pg_t pair_hi;
    assign pair_lo   = pg_combine(bit_pg[4*k+1], bit_pg[4*k]);
    assign pair_hi   = pg_combine(bit_pg[4*k+3], bit_pg[4*k+2]);
    assign blk_pg[k] = pg_combine(pair_hi, pair_lo);
  end

  // Remaining Sklansky levels over the slice groups.
  for (genvar l = 0; l <= L; l++) begin : g_lvl
    pg_t node [M];
    for (genvar j = 0; j < M; j++) begin : g_grp
      if (l == 0) begin : g_leaf
        assign node[j] = blk_pg[j];
      end else if (((j >> (l - 1)) & 1) == 1) begin : g_op
        localparam int SRC = ((j >> (l - 1)) << (l - 1)) - 1;
        assign node[j] = pg_combine(g_lvl[l-1].node[j], g_lvl[l-1].node[SRC]);
      end else begin : g_pass
        assign node[j] = g_lvl[l-1].node[j];
      end
    end
  end

  assign grp_c[0] = carry_in;
  for (genvar k = 0; k < M; k++) begin : g_sum
    assign grp_c[k+1] = g_lvl[L].node[k].g;
    assign unused_p[k] = g_lvl[L].node[k].p;

    carry_select_block u_csb (
      .a   (operand_1[4*k +: 4]),
      .b   (operand_2[4*k +: 4]),
      .cin (grp_c[k]),
      .sum (sum[4*k +: 4])
    );
  end

  assign carry_out = grp_c[M];
  assign overflow  = ~(operand_1[N_BIT-1] ^ operand_2[N_BIT-1])
                   & (sum[N_BIT-1] ^ operand_1[N_BIT-1]);

endmodule

// File: tb/tb_sparse_tree_adder.sv
// Bench for sparse_tree_adder at 128 bits: directed table, reset pulse during
// traffic, and random vectors checked against a 129-bit golden sum.
module tb_sparse_tree_adder;

  localparam int W  = 128;
  localparam int RW = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] operand_1;
  logic [W-1:0] operand_2;
  logic         carry_in;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  logic [RW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  sparse_tree_adder #(.N_BIT(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .carry_in  (carry_in),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  function automatic logic [RW-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
    logic [W:0] t;
    logic       ov;
    t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    ov = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return {t[W], ov, t[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string name);
    logic [RW-1:0] e;
    logic [RW-1:0] got;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: no expected entry queued", name);
    end else begin
      e   = exp_q.pop_front();
      got = {carry_out, overflow, sum};
      if (got !== e) begin
        n_bad++;
        $display("FAIL %s: got co=%b ov=%b sum=%h, expected co=%b ov=%b sum=%h",
                 name, got[RW-1], got[RW-2], got[W-1:0], e[RW-1], e[RW-2], e[W-1:0]);
      end
    end
  endtask

  // Drive mid-period, queue the expectation, compare at the next rising edge.
  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic [RW-1:0] e, input string name);
    @(negedge clk);
    operand_1 = a;
    operand_2 = b;
    carry_in  = cin;
    exp_q.push_back(e);
    @(posedge clk);
    check(name);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;

    rst       = 1'b1;
    operand_1 = '0;
    operand_2 = '0;
    carry_in  = 1'b0;

    tbl[0] = '{{W{1'b1}}, '0, 1'b1, '0, 1'b1, 1'b0};
    tbl[1] = '{{1'b0, {(W-1){1'b1}}}, {{(W-1){1'b0}}, 1'b1}, 1'b0,
               {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1};
    tbl[2] = '{{1'b1, {(W-1){1'b0}}}, {1'b1, {(W-1){1'b0}}}, 1'b0, '0, 1'b1, 1'b1};
    tbl[3] = '{{{(W-4){1'b0}}, 4'hf}, {{(W-1){1'b0}}, 1'b1}, 1'b0,
               {{(W-5){1'b0}}, 5'h10}, 1'b0, 1'b0};
    tbl[4] = '{{4'h0, {(W-4){1'b1}}}, '0, 1'b1, {4'h1, {(W-4){1'b0}}}, 1'b0, 1'b0};
    tbl[5] = '{'0, '0, 1'b0, '0, 1'b0, 1'b0};
    tbl[6] = '{{W{1'b1}}, {W{1'b1}}, 1'b1, {W{1'b1}}, 1'b1, 1'b0};
    tbl[7] = '{'0, '0, 1'b1, {{(W-1){1'b0}}, 1'b1}, 1'b0, 1'b0};
    tbl[8] = '{{{(W-16){1'b0}}, 16'hffff}, {{(W-1){1'b0}}, 1'b1}, 1'b0,
               {{(W-17){1'b0}}, 17'h10000}, 1'b0, 1'b0};
    tbl[9] = '{{W{1'b1}}, {{(W-1){1'b0}}, 1'b1}, 1'b0, '0, 1'b1, 1'b0};

    // First vector is applied with rst still high: outputs must already track inputs.
    for (int i = 0; i < 10; i++) begin
      if (i == 1) rst = 1'b0;
      apply(tbl[i].a, tbl[i].b, tbl[i].cin, {tbl[i].co, tbl[i].ov, tbl[i].s},
            $sformatf("table_%0d", i));
    end

    // rst pulsed for three cycles in the middle of random traffic.
    for (int i = 0; i < 20; i++) begin
      a   = rand_word();
      b   = rand_word();
      cin = 1'($urandom_range(0, 1));
      @(negedge clk);
      rst = (i >= 8 && i < 11);
      apply(a, b, cin, golden(a, b, cin), $sformatf("reset_seq_%0d", i));
    end
    rst = 1'b0;

    // Random regression with some vectors biased toward long propagate chains.
    for (int i = 0; i < 3000; i++) begin
      a   = rand_word();
      cin = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       b = ~a;
        1:       b = ~a ^ (W'(1) << $urandom_range(0, W - 1));
        default: b = rand_word();
      endcase
      apply(a, b, cin, golden(a, b, cin), $sformatf("random_%0d", i));
    end

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
